// File: rtl/mem_axil_master_bridge.sv
// Data-memory request port to AXI-Lite master bridge.
// One outstanding transaction, one-cycle ack, watchdog timeout.
module mem_axil_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [3:0]        mem_wstrb_i,
  output logic              mem_busy_o,
  output logic              mem_ack_o,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_err_o,
  output logic              m_awvalid_o,
  output logic [ADDR_W-1:0] m_awaddr_o,
  input  logic              m_awready_i,
  output logic              m_wvalid_o,
  output logic [31:0]       m_wdata_o,
  output logic [3:0]        m_wstrb_o,
  input  logic              m_wready_i,
  input  logic              m_bvalid_i,
  input  logic [1:0]        m_bresp_i,
  output logic              m_bready_o,
  output logic              m_arvalid_o,
  output logic [ADDR_W-1:0] m_araddr_o,
  input  logic              m_arready_i,
  input  logic              m_rvalid_i,
  input  logic [31:0]       m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  output logic              m_rready_o
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WRESP,
    READ
  } state_t;

  state_t        state;
  logic          aw_done;
  logic          w_done;
  logic [CW-1:0] cnt;

  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          ar_hs;
  logic          r_hs;
  logic          aw_done_n;
  logic          w_done_n;
  logic [CW-1:0] cnt_inc;
  logic          to_hit;

  assign aw_hs     = m_awvalid_o & m_awready_i;
  assign w_hs      = m_wvalid_o & m_wready_i;
  assign b_hs      = m_bready_o & m_bvalid_i;
  assign ar_hs     = m_arvalid_o & m_arready_i;
  assign r_hs      = m_rready_o & m_rvalid_i;
  assign aw_done_n = aw_done | aw_hs;
  assign w_done_n  = w_done | w_hs;
  assign cnt_inc   = cnt + CW'(1);
  // Fires on the edge where the busy-cycle count reaches the limit.
  assign to_hit    = TO_EN && (cnt_inc == TO_VAL);

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cnt         <= '0;
      mem_busy_o  <= 1'b0;
      mem_ack_o   <= 1'b0;
      mem_rdata_o <= '0;
      mem_err_o   <= 1'b0;
      m_awvalid_o <= 1'b0;
      m_awaddr_o  <= '0;
      m_wvalid_o  <= 1'b0;
      m_wdata_o   <= '0;
      m_wstrb_o   <= '0;
      m_bready_o  <= 1'b0;
      m_arvalid_o <= 1'b0;
      m_araddr_o  <= '0;
      m_rready_o  <= 1'b0;
    end else begin
      mem_ack_o <= 1'b0;
      if (state != IDLE) cnt <= cnt_inc;
      unique case (state)
        IDLE: begin
          if (mem_req_i) begin
            cnt        <= '0;
            mem_busy_o <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            if (mem_we_i) begin
              state       <= WRITE;
              m_awaddr_o  <= mem_addr_i;
              m_wdata_o   <= mem_wdata_i;
              m_wstrb_o   <= mem_wstrb_i;
              m_awvalid_o <= 1'b1;
              m_wvalid_o  <= 1'b1;
            end else begin
              state       <= READ;
              m_araddr_o  <= mem_addr_i;
              m_arvalid_o <= 1'b1;
              m_rready_o  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (to_hit) begin
            m_awvalid_o <= 1'b0;
            m_wvalid_o  <= 1'b0;
            mem_ack_o   <= 1'b1;
            mem_err_o   <= 1'b1;
            mem_rdata_o <= '0;
            mem_busy_o  <= 1'b0;
            state       <= IDLE;
          end else begin
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            if (aw_hs) m_awvalid_o <= 1'b0;
            if (w_hs) m_wvalid_o <= 1'b0;
            if (aw_done_n && w_done_n) begin
              m_bready_o <= 1'b1;
              state      <= WRESP;
            end
          end
        end
        WRESP: begin
          if (b_hs || to_hit) begin
            m_bready_o  <= 1'b0;
            mem_ack_o   <= 1'b1;
            mem_err_o   <= b_hs ? (m_bresp_i != 2'b00) : 1'b1;
            mem_rdata_o <= '0;
            mem_busy_o  <= 1'b0;
            state       <= IDLE;
          end
        end
        READ: begin
          if (r_hs || to_hit) begin
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b0;
            mem_ack_o   <= 1'b1;
            mem_err_o   <= r_hs ? (m_rresp_i != 2'b00) : 1'b1;
            mem_rdata_o <= r_hs ? m_rdata_i : '0;
            mem_busy_o  <= 1'b0;
            state       <= IDLE;
          end else if (ar_hs) begin
            m_arvalid_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axil_master_bridge.sv
// Directed bench for mem_axil_master_bridge.
// Inputs change at negedge; outputs checked at negedge.
module tb_mem_axil_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        busy, ack, err;
  logic [31:0] rdata;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] awaddr, wd;
  logic [3:0]  ws;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, s_rdata;
  logic [1:0]  rresp;
  logic [31:0] tx;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_axil_master_bridge #(
    .TIMEOUT_CYCLES(16),
    .ADDR_W(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mem_req_i(req),
    .mem_we_i(we),
    .mem_addr_i(addr),
    .mem_wdata_i(wdata),
    .mem_wstrb_i(wstrb),
    .mem_busy_o(busy),
    .mem_ack_o(ack),
    .mem_rdata_o(rdata),
    .mem_err_o(err),
    .m_awvalid_o(awvalid),
    .m_awaddr_o(awaddr),
    .m_awready_i(awready),
    .m_wvalid_o(wvalid),
    .m_wdata_o(wd),
    .m_wstrb_o(ws),
    .m_wready_i(wready),
    .m_bvalid_i(bvalid),
    .m_bresp_i(bresp),
    .m_bready_o(bready),
    .m_arvalid_o(arvalid),
    .m_araddr_o(araddr),
    .m_arready_i(arready),
    .m_rvalid_i(rvalid),
    .m_rdata_i(s_rdata),
    .m_rresp_i(rresp),
    .m_rready_o(rready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d; wstrb = 4'hF;
  endtask

  // UART-lite style read: arready and rvalid in the same cycle.
  task automatic rd_uart(input logic [31:0] a, input logic [31:0] d);
    step(); issue(1'b0, a, 32'h0);
    step(); req = 1'b0;
    chk("rd_ar_r", {arvalid, rready, busy}, 3'b111);
    chk("rd_araddr", araddr, a);
    arready = 1'b1; rvalid = 1'b1; s_rdata = d; rresp = 2'b00;
    step();
    chk("rd_ack", {ack, err, busy, arvalid, rready}, 5'b10000);
    chk("rd_data", rdata, d);
    arready = 1'b0; rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    wstrb = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    bresp = '0; arready = 1'b0; rvalid = 1'b0; s_rdata = '0;
    rresp = '0; tx = '0;
    step();
    chk("rst_ctl", {busy, ack, err, awvalid, wvalid, bready,
                    arvalid, rready}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_awaddr", awaddr, 32'h0);
    rst = 1'b0;

    // Read of status register right after reset.
    rd_uart(32'h08, 32'h4);

    // Write 0x41 to TX; W handshake before AW.
    step(); issue(1'b1, 32'h04, 32'h41);
    step(); req = 1'b0;
    chk("wr_valids", {awvalid, wvalid, busy}, 3'b111);
    chk("wr_strb", {28'h0, ws}, 32'hF);
    wready = 1'b1; tx = wd;
    step();
    chk("wr_w_drop", {awvalid, wvalid}, 2'b10);
    wready = 1'b0; awready = 1'b1;
    step();
    chk("wr_bready", {awvalid, wvalid, bready}, 3'b001);
    chk("wr_awaddr", awaddr, 32'h04);
    awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
    step();
    chk("wr_ack", {ack, err, busy, bready}, 4'b1000);
    chk("wr_rdata", rdata, 32'h0);
    chk("wr_tx", tx, 32'h41);
    bvalid = 1'b0;

    // Error response; request while busy is dropped.
    step(); issue(1'b1, 32'h10, 32'h5);
    step();
    issue(1'b1, 32'h20, 32'h6);
    awready = 1'b1; wready = 1'b1;
    step(); req = 1'b0;
    chk("er_bready", {awvalid, wvalid, bready}, 3'b001);
    chk("er_awaddr", awaddr, 32'h10);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
    step();
    chk("er_ack", {ack, err}, 2'b11);
    bvalid = 1'b0; bresp = 2'b00;
    step();
    chk("er_idle", {ack, busy, awvalid, wvalid, bready}, 5'b0);

    // Unresponsive slave: forced error after 16 busy cycles.
    step(); issue(1'b1, 32'h30, 32'h7);
    step(); req = 1'b0;
    for (int k = 1; k < 16; k++) begin
      chk("to_wait", {ack, busy, awvalid}, 3'b011);
      step();
    end
    chk("to_last", {ack, busy, awvalid}, 3'b011);
    step();
    chk("to_ack", {ack, err, busy, awvalid, wvalid}, 5'b11000);
    chk("to_rdata", rdata, 32'h0);
    bvalid = 1'b1;
    step();
    chk("to_late_b", {ack, bready, busy}, 3'b000);
    bvalid = 1'b0;

    // Read issued in the ack cycle of a write.
    step(); issue(1'b1, 32'h40, 32'h8);
    step(); req = 1'b0; awready = 1'b1; wready = 1'b1;
    step();
    chk("bb_bready", bready, 1'b1);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    step();
    chk("bb_wack", {ack, busy}, 2'b10);
    bvalid = 1'b0; issue(1'b0, 32'h44, 32'h0);
    step(); req = 1'b0;
    chk("bb_arvalid", {arvalid, busy}, 2'b11);
    chk("bb_araddr", araddr, 32'h44);
    chk("bb_awaddr", awaddr, 32'h40);
    arready = 1'b1; rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
    step();
    chk("bb_rack", {ack, err}, 2'b10);
    chk("bb_rdata", rdata, 32'hDEADBEEF);
    arready = 1'b0; rvalid = 1'b0;

    // Asynchronous reset in the middle of WRESP.
    step(); issue(1'b1, 32'h50, 32'h9);
    step(); req = 1'b0; awready = 1'b1; wready = 1'b1;
    step();
    chk("rs_bready", bready, 1'b1);
    awready = 1'b0; wready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rs_async", {busy, ack, err, bready, awvalid, wvalid,
                     arvalid, rready}, 32'h0);
    chk("rs_awaddr", awaddr, 32'h0);
    #1 rst = 1'b0;
    bvalid = 1'b1;
    step();
    chk("rs_noack", {ack, busy, bready}, 3'b000);
    bvalid = 1'b0;
    rd_uart(32'h08, 32'h4);

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_axil_master_bridge.md
Name: mem_axil_master_bridge

Overview:
- Converts the core's single-request data-memory port into AXI-Lite master transactions.
- Drives the cfg_* slave port of the UART-lite and other peripheral slaves.
- One outstanding transaction at a time; each request returns a one-cycle ack carrying read data and error status.
- A watchdog timeout keeps the core from hanging on an unresponsive slave.

Parameters:
TIMEOUT_CYCLES, 1024, cycles allowed per transaction before forced error completion; 0 disables the timeout
ADDR_W, 32, address width on both sides

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
mem_req_i  in  1  request strobe; accepted only when mem_busy_o=0
mem_we_i  in  1  1=write, 0=read
mem_addr_i  in  ADDR_W  byte address
mem_wdata_i  in  32  write data
mem_wstrb_i  in  4  byte strobes
mem_busy_o  out  1  transaction in flight
mem_ack_o  out  1  one-cycle completion pulse
mem_rdata_o  out  32  read data; valid while mem_ack_o=1
mem_err_o  out  1  error flag; valid while mem_ack_o=1
m_awvalid_o  out  1  write-address valid
m_awaddr_o  out  ADDR_W  write address
m_awready_i  in  1  write-address ready
m_wvalid_o  out  1  write-data valid
m_wdata_o  out  32  write data
m_wstrb_o  out  4  write strobes
m_wready_i  in  1  write-data ready
m_bvalid_i  in  1  write response valid
m_bresp_i  in  2  write response
m_bready_o  out  1  write response ready
m_arvalid_o  out  1  read-address valid
m_araddr_o  out  ADDR_W  read address
m_arready_i  in  1  read-address ready
m_rvalid_i  in  1  read data valid
m_rdata_i  in  32  read data
m_rresp_i  in  2  read response
m_rready_o  out  1  read data ready

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, aw_done=w_done=0, timeout counter 0.
  - Reset is asynchronous and aborts any in-flight transaction immediately.
- States: IDLE, WRITE, WRESP, READ.
- Acceptance: at the edge ending cycle T where mem_req_i=1 and state=IDLE:
  - Capture addr/wdata/wstrb into registers.
  - mem_busy_o=1 from T+1.
- Address/data stability:
  - m_awaddr_o, m_araddr_o, m_wdata_o and m_wstrb_o come from the capture registers.
  - They stay stable from T+1 until the ack cycle, because the slave samples the address after the handshake.
  - mem_req_i while busy is ignored and not queued.
- WRITE:
  - m_awvalid_o=m_wvalid_o=1 from T+1, asserted together.
  - Each valid drops the cycle after its own valid&ready edge (sets aw_done / w_done).
  - Valids never depend combinationally on ready.
  - When both done -> WRESP.
  - Handshakes may complete on the same edge or on different edges, in either order.
- WRESP:
  - m_bready_o=1.
  - On the bvalid&bready edge: bready drops; mem_ack_o=1 for 1 cycle; mem_err_o=(bresp!=2'b00); mem_rdata_o=0; -> IDLE.
- READ:
  - m_arvalid_o=1 and m_rready_o=1 from T+1.
  - arvalid drops after the arvalid&arready edge.
  - Completion on the rvalid&rready edge: mem_ack_o=1; mem_rdata_o=m_rdata_i; mem_err_o=(rresp!=2'b00); arvalid and rready forced 0; -> IDLE.
  - Slaves such as the UART-lite raise arready and rvalid in the same cycle; this must complete in one edge.
- Ack cycle:
  - mem_busy_o=0 in the cycle mem_ack_o=1.
  - A new mem_req_i in that cycle is accepted, so back-to-back issue spacing is one idle-free cycle.
- Timeout:
  - Counter clears on acceptance and increments each non-IDLE cycle.
  - On reaching TIMEOUT_CYCLES: all valid/ready outputs drop; mem_ack_o=1; mem_err_o=1; mem_rdata_o=0; -> IDLE.
  - If a completion handshake occurs on the same edge, the real completion wins.
  - Late responses arriving while IDLE are ignored, since bready/rready are 0.
  - Counter width: clog2(TIMEOUT_CYCLES+1).
- mem_rdata_o/mem_err_o hold their values after ack until the next ack; only the ack cycle is meaningful.

Test Plan:
- Write 0x41 to UART-lite addr 0x04 with wstrb=0xF -> awvalid and wvalid both high at T+1, held until awready; awaddr stays 0x04 through bready; ack pulse with err=0; slave TX register = 0x41.
- Read addr 0x08 right after reset from a UART-lite slave (arready and rvalid in the same cycle) -> single-edge completion; mem_rdata_o=0x00000004; err=0; arvalid high exactly 1 cycle beyond the slave's first observation.
- Write to addr 0x10 (slave returns bresp=2'b10) -> ack with err=1; a second write while the first is busy is dropped, with no extra AXI activity.
- Slave never asserts awready, TIMEOUT_CYCLES=16 -> ack with err=1 at exactly 16 cycles after acceptance; all valids 0 afterwards; a later bvalid causes no ack.
- Read issued on the ack cycle of a previous write -> accepted; arvalid high the next cycle; both acks observed; awaddr/araddr independent.
- rst_i pulsed mid-WRESP -> all outputs 0 asynchronously; state IDLE; no ack; next request completes normally.
